// File: rtl/mdu_pkg.sv
// Shared types, funct3 op codes and operand-sign predicates for the RV32M sequencer.
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_t;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: restoring-divide step or shift-add multiply step.
// With MDU_FAST_MUL_EN defined only the divide step is built.
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_work,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_work
);

  // Top XLEN+1 bits after the left shift; the extra bit keeps a partial remainder >= 2^XLEN.
  logic [XLEN:0]     w_part;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_part     = i_work[2*XLEN-1:XLEN-1];
  assign w_diff     = w_part - {1'b0, i_opnd};
  assign w_div_next = w_diff[XLEN] ? {w_part[XLEN-1:0], i_work[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], i_work[XLEN-2:0], 1'b1};

`ifdef MDU_FAST_MUL_EN
  assign o_work = i_is_div ? w_div_next : i_work;
`else
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_sum      = i_work[0] ? ({1'b0, i_work[2*XLEN-1:XLEN]} + {1'b0, i_opnd})
                                : {1'b0, i_work[2*XLEN-1:XLEN]};
  assign w_mul_next = {w_sum, i_work[XLEN-1:1]};
  assign o_work     = i_is_div ? w_div_next : w_mul_next;
`endif

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: FSM, counter, sign handling and result fixup.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply instead of shift-add.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  import mdu_pkg::*;

  mdu_state_t        r_state;
  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_work;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic              r_neg;
  logic              r_busy;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_is_div;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_start_neg;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign w_is_div    = is_div(op_i);
  assign w_a_neg     = is_signed_a(op_i) & rs1_i[XLEN-1];
  assign w_b_neg     = is_signed_b(op_i) & rs2_i[XLEN-1];
  assign w_a_mag     = w_a_neg ? -rs1_i : rs1_i;
  assign w_b_mag     = w_b_neg ? -rs2_i : rs2_i;
  // Remainder follows the dividend; quotient and products follow the sign difference.
  assign w_start_neg = (op_i == MDU_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0      = w_is_div && (rs2_i == '0);
  assign w_ovf       = ((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                       (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign w_special   = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (op_i[1] ? rs1_i : '1)
                                : (op_i[1] ? '0 : rs1_i);

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa;
  logic signed [XLEN:0]     w_fb;
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fast_res;

  assign w_fa       = {is_signed_a(op_i) & rs1_i[XLEN-1], rs1_i};
  assign w_fb       = {is_signed_b(op_i) & rs2_i[XLEN-1], rs2_i};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast_res = (op_i == MDU_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .i_is_div (is_div(r_op)),
    .i_work   (r_work),
    .i_opnd   (r_opnd),
    .o_work   (w_next)
  );

  assign w_prod = r_neg ? -r_work : r_work;
  assign w_quo  = r_neg ? -r_work[XLEN-1:0] : r_work[XLEN-1:0];
  assign w_rem  = r_neg ? -r_work[2*XLEN-1:XLEN] : r_work[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      MDU_MUL:            w_fix_res = w_prod[XLEN-1:0];
      MDU_DIV, MDU_DIVU:  w_fix_res = w_quo;
      MDU_REM, MDU_REMU:  w_fix_res = w_rem;
      default:            w_fix_res = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_work   <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (flush_i) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start_i) begin
              r_op  <= op_i;
              r_neg <= w_start_neg;
              r_cnt <= CNT_W'(XLEN-1);
              // Divide: dividend in the low half, divisor as operand; multiply: the reverse.
              r_work <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_opnd <= w_is_div ? w_b_mag : w_a_mag;
              if (w_special) begin
                r_result <= w_special_res;
                r_state  <= DONE;
                r_valid  <= 1'b1;
                r_busy   <= 1'b0;
`ifdef MDU_FAST_MUL_EN
              end else if (!w_is_div) begin
                r_result <= w_fast_res;
                r_state  <= DONE;
                r_valid  <= 1'b1;
                r_busy   <= 1'b0;
`endif
              end else begin
                r_state <= CALC;
                r_busy  <= 1'b1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
          CALC: begin
            r_work <= w_next;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) r_state <= FIXUP;
          end
          FIXUP: begin
            r_result <= w_fix_res;
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign result_o = r_result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed RV32M corner cases plus randomized ops.
`timescale 1ns/1ps
module tb_mdu_sequencer;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int busy_cnt = 0;
  logic [XLEN-1:0] last_res = '0;

  logic [XLEN-1:0] exp_q[$];
  int              due_q[$];
  int              busy_q[$];

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  // clock / cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the RV32M rules, using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 34;
  endfunction

  // driver tasks: called just after a rising edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int due);
    int l;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    l       = latency(op, a, b);
    due     = cyc + l;
    exp_q.push_back(ref_model(op, a, b));
    due_q.push_back(due);
    busy_q.push_back((l == 34) ? 33 : 0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding after 200 cycles, 0 required", exp_q.size());
      exp_q.delete(); due_q.delete(); busy_q.delete();
    end
  endtask

  task automatic wait_until(input int due);
    int n = 0;
    while (cyc < due && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [XLEN-1:0] e;
    int d, b;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        busy_cnt = 0;
      end else begin
        if (flush_i) busy_cnt = 0;
        else if (busy_o) busy_cnt++;
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: result 0x%0h with no operation outstanding (cycle %0d)",
                     result_o, cyc);
          end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            b = busy_q.pop_front();
            check("result", result_o, e);
            check("valid_cycle", cyc, d);
            check("busy_cycles", busy_cnt, b);
            last_res = e;
          end
          busy_cnt = 0;
        end
      end
    end
  end

  logic [2:0]  t_op [12] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd4, 3'd6, 3'd1, 3'd2, 3'd0, 3'd3, 3'd5, 3'd6};
  logic [31:0] t_a  [12] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd7, 32'h8000_0000, 32'h8000_0000,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'd17};
  logic [31:0] t_b  [12] = '{32'd3, 32'd3, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0};

  initial begin
    int due;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n_i = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_result", result_o, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i], due);
      wait_idle();
    end

    // flush mid-divide, then restart immediately
    issue(3'd4, 32'd100, 32'd7, due);
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    void'(exp_q.pop_back());
    void'(due_q.pop_back());
    void'(busy_q.pop_back());
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_busy", busy_o, 0);
    check("flush_valid", valid_o, 0);
    check("flush_result_held", result_o, last_res);
    issue(3'd5, 32'd100, 32'd7, due);
    wait_idle();

    // back-to-back issue in the DONE cycle
    issue(3'd5, 32'd1000, 32'd9, due);
    wait_until(due);
    issue(3'd5, 32'hDEAD_BEEF, 32'd13, due);
    wait_idle();

    // asynchronous reset in the middle of CALC
    issue(3'd4, 32'd1000, 32'd3, due);
    repeat (10) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_valid", valid_o, 0);
    check("async_rst_result", result_o, 0);
    exp_q.delete(); due_q.delete(); busy_q.delete();
    last_res = '0;
    @(negedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // randomized operations, some issued back-to-back
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      issue(op, a, b, due);
      if ($urandom_range(0, 1) == 1) wait_until(due);
      else wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
